counter_selector_sequencer: RTL

//  Command-side driver for the 4-channel up/down counter selector system. On a start

---
 rtl/counter_selector_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/counter_selector_sequencer.sv
// Command-side driver that walks each counter channel through an up/down/complement/gap schedule
// and reports the selected counter value captured at the end of every phase.
module counter_selector_sequencer #(
   parameter int WIDTH       = 8,
   parameter int NUM_SEL     = 4,
   parameter int UP_CYCLES   = 3,
   parameter int DOWN_CYCLES = 1,
   parameter int COMP_CYCLES = 1,
   parameter int GAP_CYCLES  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [1:0]       sel,
   output logic             up_down,
   output logic             comp,
   input  logic [WIDTH-1:0] yout_in,
   output logic             busy,
   output logic             done,
   output logic             sample_valid,
   output logic [1:0]       sample_sel,
   output logic [1:0]       sample_phase,
   output logic [WIDTH-1:0] sample_data
);

   localparam int M1    = (UP_CYCLES > DOWN_CYCLES) ? UP_CYCLES : DOWN_CYCLES;
   localparam int M2    = (COMP_CYCLES > GAP_CYCLES) ? COMP_CYCLES : GAP_CYCLES;
   localparam int MAX_C = (M1 > M2) ? M1 : M2;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] UP_LD   = CW'(UP_CYCLES - 1);
   localparam logic [CW-1:0] DOWN_LD = CW'(DOWN_CYCLES - 1);
   localparam logic [CW-1:0] COMP_LD = CW'(COMP_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
   localparam logic [1:0]    LAST_SEL = 2'(NUM_SEL - 1);

   typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_COMP, S_GAP, S_DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          w_active;
   logic          w_end;
   logic [1:0]    w_phase;

   // Phase counter is loaded with length-1 on entry, so zero marks the final cycle.
   assign w_end = (r_cnt == '0);

   always_comb begin
      w_active = 1'b1;
      w_phase  = 2'd0;
      case (r_state)
         S_UP:    w_phase = 2'd0;
         S_DOWN:  w_phase = 2'd1;
         S_COMP:  w_phase = 2'd2;
         S_GAP:   w_phase = 2'd3;
         default: w_active = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         sel          <= '0;
         up_down      <= 1'b0;
         comp         <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sample_valid <= 1'b0;
         sample_sel   <= '0;
         sample_phase <= '0;
         sample_data  <= '0;
      end else begin
         done         <= 1'b0;
         sample_valid <= 1'b0;
         if (w_active && w_end) begin
            sample_valid <= 1'b1;
            sample_sel   <= sel;
            sample_phase <= w_phase;
            sample_data  <= yout_in;
         end
         if (w_active && !w_end)
            r_cnt <= r_cnt - CW'(1);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_UP;
                  r_cnt   <= UP_LD;
                  busy    <= 1'b1;
                  sel     <= '0;
                  up_down <= 1'b0;
                  comp    <= 1'b0;
               end
            end
            S_UP: begin
               if (w_end) begin
                  r_state <= S_DOWN;
                  r_cnt   <= DOWN_LD;
                  up_down <= 1'b1;
               end
            end
            S_DOWN: begin
               if (w_end) begin
                  r_state <= S_COMP;
                  r_cnt   <= COMP_LD;
                  comp    <= 1'b1;
               end
            end
            S_COMP: begin
               if (w_end) begin
                  r_state <= S_GAP;
                  r_cnt   <= GAP_LD;
                  comp    <= 1'b0;
               end
            end
            S_GAP: begin
               if (w_end) begin
                  up_down <= 1'b0;
                  if (sel == LAST_SEL) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     sel     <= '0;
                  end else begin
                     r_state <= S_UP;
                     r_cnt   <= UP_LD;
                     sel     <= sel + 2'd1;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
